// File: rtl/adam_clk_div_cfg.sv
// adam_clk_div_cfg: run-time programmable 50% clock divider with rise-aligned tick and glitch-free ratio update
module adam_clk_div_cfg #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic [WIDTH-1:0] div_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic             err_o
);
    typedef enum logic {IDLE, PENDING} state_e;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
    state_e state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
    logic clk_q, clk_d, tick_q, tick_d, err_q, err_d, ready_q, ready_d;
    logic wrap, rise;
    assign wrap = en_i && (cnt_q == div_q - ONE);
    assign rise = wrap && !clk_q;
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        div_d   = div_q;
        ready_d = ready_q;
        cnt_d   = en_i ? (wrap ? '0 : cnt_q + ONE) : cnt_q;
        clk_d   = wrap ? ~clk_q : clk_q;
        tick_d  = rise;
        err_d   = 1'b0;
        if (state_q == IDLE && div_valid_i) begin
            if (div_i != '0) begin
                pend_d  = div_i;
                ready_d = 1'b0;
                state_d = PENDING;
            end else begin
                err_d = 1'b0 | 1'b1;
            end
        end else if (state_q == PENDING && rise) begin
            // The new ratio takes over exactly at the rising edge, so the high phase starting here uses it
            div_d   = pend_q;
            ready_d = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DEF;
            pend_q  <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end
    assign div_ready_o = ready_q;
    assign div_o       = div_q;
    assign clk_o       = clk_q;
    assign tick_o      = tick_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_adam_clk_div_cfg.sv
// tb_adam_clk_div_cfg: directed checks of the programmable divider against hand-derived edge-by-edge waveforms
module tb_adam_clk_div_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_i = 1'b1;
    logic [7:0] div_i = '0;
    logic div_valid_i = 1'b0;
    logic div_ready_o, clk_o, tick_o, err_o;
    logic [7:0] div_o;
    logic div_ready4, clk4, tick4, err4;
    logic [7:0] div4;
    logic [11:0] obs, obs4;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    adam_clk_div_cfg #(.WIDTH(8), .DEFAULT_DIV(2)) u_dut (
        .clk(clk), .rst(rst), .en_i(en_i), .div_i(div_i), .div_valid_i(div_valid_i),
        .div_ready_o(div_ready_o), .div_o(div_o), .clk_o(clk_o), .tick_o(tick_o), .err_o(err_o)
    );
    adam_clk_div_cfg #(.WIDTH(8), .DEFAULT_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .en_i(en_i), .div_i(div_i), .div_valid_i(div_valid_i),
        .div_ready_o(div_ready4), .div_o(div4), .clk_o(clk4), .tick_o(tick4), .err_o(err4)
    );

    assign obs  = {clk_o, tick_o, div_ready_o, err_o, div_o};
    assign obs4 = {clk4, tick4, div_ready4, err4, div4};

    // Expected vector layout: {clk_o, tick_o, div_ready_o, err_o, div_o}
    function automatic logic [11:0] v(input bit c, input bit t, input bit r, input bit e, input int d);
        return {c, t, r, e, 8'(d)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after "edge 0", the last edge that samples rst high
    task automatic reset_dut();
        rst = 1'b1;
        en_i = 1'b1;
        div_valid_i = 1'b0;
        div_i = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        nvec++;
        if (obs !== v(0, 0, 1, 0, 2)) begin
            nerr++;
            $display("FAIL reset_n2: got clk/tick/rdy/err/div=%b_%0d exp %b_%0d", obs[11:8], obs[7:0], 4'b0010, 2);
        end
        nvec++;
        if (obs4 !== v(0, 0, 1, 0, 4)) begin
            nerr++;
            $display("FAIL reset_n4: got clk/tick/rdy/err/div=%b_%0d exp %b_%0d", obs4[11:8], obs4[7:0], 4'b0010, 4);
        end
    endtask

    task automatic test_default();
        logic [11:0] e;
        reset_dut();
        for (int k = 1; k <= 11; k++) begin
            step();
            e = v(k >= 2 && ((k - 2) % 4) < 2, k >= 2 && ((k - 2) % 4) == 0, 1, 0, 2);
            nvec++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL default edge %0d: got %b_%0d exp %b_%0d", k, obs[11:8], obs[7:0], e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_change();
        logic [11:0] e [9];
        e = '{v(0,0,0,0,2), v(0,0,0,0,2), v(1,1,1,0,3), v(1,0,1,0,3), v(1,0,1,0,3),
              v(0,0,1,0,3), v(0,0,1,0,3), v(0,0,1,0,3), v(1,1,1,0,3)};
        reset_dut();
        step(); step(); step();
        div_i = 8'd3;
        div_valid_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            div_valid_i = 1'b0;
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL change edge %0d: got %b_%0d exp %b_%0d", i + 4, obs[11:8], obs[7:0], e[i][11:8], e[i][7:0]);
            end
        end
    endtask

    task automatic test_zero();
        logic [11:0] e [5];
        e = '{v(1,1,1,1,2), v(1,0,1,0,2), v(0,0,1,0,2), v(0,0,1,0,2), v(1,1,1,0,2)};
        reset_dut();
        step();
        div_i = 8'd0;
        div_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            div_valid_i = 1'b0;
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL zero edge %0d: got %b_%0d exp %b_%0d", i + 2, obs[11:8], obs[7:0], e[i][11:8], e[i][7:0]);
            end
        end
    endtask

    task automatic test_reset_pending();
        logic [11:0] e [5];
        e = '{v(0,0,1,0,4), v(0,0,1,0,4), v(0,0,1,0,4), v(0,0,1,0,4), v(1,1,1,0,4)};
        reset_dut();
        step();
        div_i = 8'd1;
        div_valid_i = 1'b1;
        step();
        div_valid_i = 1'b0;
        nvec++;
        if (obs4 !== v(0, 0, 0, 0, 4)) begin
            nerr++;
            $display("FAIL rstpend accept: got %b_%0d exp %b_%0d", obs4[11:8], obs4[7:0], 4'b0000, 4);
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            rst = 1'b0;
            nvec++;
            if (obs4 !== e[i]) begin
                nerr++;
                $display("FAIL rstpend edge %0d: got %b_%0d exp %b_%0d", i + 4, obs4[11:8], obs4[7:0], e[i][11:8], e[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e [10];
        e = '{v(1,1,0,0,2), v(1,0,0,0,2), v(0,0,0,0,2), v(0,0,0,0,2), v(1,1,1,0,5),
              v(1,0,1,0,5), v(1,0,1,0,5), v(1,0,1,0,5), v(1,0,1,0,5), v(0,0,1,0,5)};
        reset_dut();
        step();
        div_i = 8'd5;
        div_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            div_valid_i = 1'b0;
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL b2b edge %0d: got %b_%0d exp %b_%0d", i + 2, obs[11:8], obs[7:0], e[i][11:8], e[i][7:0]);
            end
        end
    endtask

    task automatic test_freeze();
        logic [11:0] e [7];
        e = '{v(1,0,0,0,2), v(1,0,0,0,2), v(1,0,0,0,2), v(1,0,0,0,2), v(0,0,0,0,2),
              v(0,0,0,0,2), v(1,1,1,0,7)};
        reset_dut();
        step(); step();
        en_i = 1'b0;
        div_i = 8'd7;
        div_valid_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            div_valid_i = 1'b0;
            if (i == 2) en_i = 1'b1;
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL freeze edge %0d: got %b_%0d exp %b_%0d", i + 3, obs[11:8], obs[7:0], e[i][11:8], e[i][7:0]);
            end
        end
    endtask

    task automatic test_n1();
        logic [11:0] e [8];
        e = '{v(1,1,0,0,2), v(1,0,0,0,2), v(0,0,0,0,2), v(0,0,0,0,2),
              v(1,1,1,0,1), v(0,0,1,0,1), v(1,1,1,0,1), v(0,0,1,0,1)};
        reset_dut();
        step();
        div_i = 8'd1;
        div_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            div_valid_i = 1'b0;
            nvec++;
            if (obs !== e[i]) begin
                nerr++;
                $display("FAIL n1 edge %0d: got %b_%0d exp %b_%0d", i + 2, obs[11:8], obs[7:0], e[i][11:8], e[i][7:0]);
            end
        end
    endtask

    task automatic test_max();
        logic [11:0] e;
        reset_dut();
        step();
        div_i = 8'd255;
        div_valid_i = 1'b1;
        step();
        div_valid_i = 1'b0;
        step(); step(); step(); step();
        nvec++;
        if (obs !== v(1, 1, 1, 0, 255)) begin
            nerr++;
            $display("FAIL max apply: got %b_%0d exp %b_%0d", obs[11:8], obs[7:0], 4'b1110, 255);
        end
        for (int k = 7; k <= 262; k++) begin
            step();
            e = v(k < 261, 0, 1, 0, 255);
            nvec++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL max edge %0d: got %b_%0d exp %b_%0d", k, obs[11:8], obs[7:0], e[11:8], e[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_change();
        test_zero();
        test_reset_pending();
        test_back_to_back();
        test_freeze();
        test_n1();
        test_max();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
